// File: rtl/legv8_pkg.sv
// Shared widths, XZR index, ALU opcode encoding and the ID/EX register layout
// for the LEGv8 execute front end.
package legv8_pkg;
   localparam int DW = 64;
   localparam int RW = 5;
   localparam logic [RW-1:0] XZR = 5'd31;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_LUI = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef struct packed {
      logic          valid;
      logic [3:0]    op;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic [RW-1:0] rd;
      logic [DW-1:0] rs1_val;
      logic [DW-1:0] rs2_val;
      logic [DW-1:0] imm;
      logic          use_imm;
      logic [5:0]    shamt;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
   } id_ex_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, writer feedback ports and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if;
   import legv8_pkg::*;

   logic          id_valid;
   logic [3:0]    id_alu_op;
   logic [RW-1:0] id_rs1;
   logic [RW-1:0] id_rs2;
   logic [RW-1:0] id_rd;
   logic [DW-1:0] id_rs1_data;
   logic [DW-1:0] id_rs2_data;
   logic [DW-1:0] id_imm;
   logic          id_use_imm;
   logic [5:0]    id_shamt;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          id_mem_write;
   logic          hold;
   logic          flush;
   logic [RW-1:0] exm_rd;
   logic          exm_reg_write;
   logic [DW-1:0] exm_result;
   logic [RW-1:0] wb_rd;
   logic          wb_reg_write;
   logic [DW-1:0] wb_result;

   logic          ex_valid;
   logic [3:0]    ex_op;
   logic [DW-1:0] ex_a;
   logic [DW-1:0] ex_b;
   logic [5:0]    ex_shamt;
   logic [RW-1:0] ex_rd;
   logic          ex_reg_write;
   logic          ex_mem_read;
   logic          ex_mem_write;
   logic [DW-1:0] ex_store_data;
   logic          load_use_stall;

   modport master (
      output id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
             id_imm, id_use_imm, id_shamt, id_reg_write, id_mem_read, id_mem_write,
             hold, flush, exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
      input  ex_valid, ex_op, ex_a, ex_b, ex_shamt, ex_rd, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_store_data, load_use_stall
   );

   modport slave (
      input  id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
             id_imm, id_use_imm, id_shamt, id_reg_write, id_mem_read, id_mem_write,
             hold, flush, exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
      output ex_valid, ex_op, ex_a, ex_b, ex_shamt, ex_rd, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_store_data, load_use_stall
   );
endinterface

// File: rtl/fwd_mux.sv
// Operand bypass: EX/MEM beats MEM/WB beats the registered value; XZR always reads 0.
module fwd_mux
   import legv8_pkg::*;
(
   input  logic [RW-1:0] src,
   input  logic [DW-1:0] reg_val,
   input  logic [RW-1:0] exm_rd,
   input  logic          exm_reg_write,
   input  logic [DW-1:0] exm_result,
   input  logic [RW-1:0] wb_rd,
   input  logic          wb_reg_write,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] fwd_val
);
   always_comb begin
      fwd_val = reg_val;
      if (src == XZR)
         fwd_val = '0;
      else if (exm_reg_write && exm_rd == src)
         fwd_val = exm_result;
      else if (wb_reg_write && wb_rd == src)
         fwd_val = wb_result;
   end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with combinational operand forwarding, load-use
// bubble insertion, downstream hold and branch flush.
module id_ex_stage
   import legv8_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   id_ex_stage_if.slave  bus
);
   id_ex_t        st_q;
   id_ex_t        st_d;
   logic [DW-1:0] fwd_a;
   logic [DW-1:0] fwd_b;
   logic [DW-1:0] fwd_st;
   logic          lus;

   fwd_mux u_fwd_a (
      .src(st_q.rs1), .reg_val(st_q.rs1_val),
      .exm_rd(bus.exm_rd), .exm_reg_write(bus.exm_reg_write), .exm_result(bus.exm_result),
      .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .wb_result(bus.wb_result),
      .fwd_val(fwd_a)
   );

   fwd_mux u_fwd_b (
      .src(st_q.rs2), .reg_val(st_q.rs2_val),
      .exm_rd(bus.exm_rd), .exm_reg_write(bus.exm_reg_write), .exm_result(bus.exm_result),
      .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .wb_result(bus.wb_result),
      .fwd_val(fwd_b)
   );

   fwd_mux u_fwd_st (
      .src(st_q.rs2), .reg_val(st_q.rs2_val),
      .exm_rd(bus.exm_rd), .exm_reg_write(bus.exm_reg_write), .exm_result(bus.exm_result),
      .wb_rd(bus.wb_rd), .wb_reg_write(bus.wb_reg_write), .wb_result(bus.wb_result),
      .fwd_val(fwd_st)
   );

   assign lus = st_q.valid && st_q.mem_read && (st_q.rd != XZR) && bus.id_valid &&
                ((st_q.rd == bus.id_rs1) || ((st_q.rd == bus.id_rs2) && !bus.id_use_imm));

   assign bus.ex_valid       = st_q.valid;
   assign bus.ex_op          = st_q.op;
   assign bus.ex_a           = fwd_a;
   assign bus.ex_b           = st_q.use_imm ? st_q.imm : fwd_b;
   assign bus.ex_shamt       = st_q.shamt;
   assign bus.ex_rd          = st_q.valid ? st_q.rd : '0;
   assign bus.ex_reg_write   = st_q.valid & st_q.reg_write;
   assign bus.ex_mem_read    = st_q.valid & st_q.mem_read;
   assign bus.ex_mem_write   = st_q.valid & st_q.mem_write;
   assign bus.ex_store_data  = fwd_st;
   assign bus.load_use_stall = lus;

   always_comb begin
      st_d = st_q;
      if (bus.flush) begin
         st_d.valid     = 1'b0;
         st_d.reg_write = 1'b0;
         st_d.mem_read  = 1'b0;
         st_d.mem_write = 1'b0;
      end else if (bus.hold) begin
         // Capture bypassed values so a writer retiring during the stall is not lost.
         st_d.rs1_val = fwd_a;
         st_d.rs2_val = fwd_b;
      end else if (lus) begin
         st_d.valid     = 1'b0;
         st_d.reg_write = 1'b0;
         st_d.mem_read  = 1'b0;
         st_d.mem_write = 1'b0;
      end else begin
         st_d.valid     = bus.id_valid;
         st_d.op        = bus.id_alu_op;
         st_d.rs1       = bus.id_rs1;
         st_d.rs2       = bus.id_rs2;
         st_d.rd        = bus.id_rd;
         st_d.rs1_val   = bus.id_rs1_data;
         st_d.rs2_val   = bus.id_rs2_data;
         st_d.imm       = bus.id_imm;
         st_d.use_imm   = bus.id_use_imm;
         st_d.shamt     = bus.id_shamt;
         st_d.reg_write = bus.id_reg_write;
         st_d.mem_read  = bus.id_mem_read;
         st_d.mem_write = bus.id_mem_write;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         st_q <= '0;
      else
         st_q <= st_d;
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed hazard scenarios plus randomized traffic, checked every cycle against
// an instruction-level model of the ID/EX stage.
module tb_id_ex_stage;
   import legv8_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   id_ex_stage_if bus();
   id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad = 0;

   typedef struct {
      bit          valid;
      logic [3:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] v1, v2, imm;
      bit          use_imm;
      logic [5:0]  shamt;
      bit          rw, mr, mw;
   } instr_t;

   instr_t m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] alu(input logic [3:0] op, input logic [63:0] a,
                                       input logic [63:0] b, input logic [5:0] sh);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_XOR: return a ^ b;
         ALU_SLL: return a << sh;
         ALU_SRL: return a >> sh;
         ALU_SUB: return a - b;
         ALU_LUI: return b << 16;
         ALU_NOR: return ~(a | b);
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] fwd(input logic [4:0] s, input logic [63:0] v);
      if (s == 5'd31) return 64'd0;
      if (bus.exm_reg_write && bus.exm_rd == s) return bus.exm_result;
      if (bus.wb_reg_write && bus.wb_rd == s) return bus.wb_result;
      return v;
   endfunction

   function automatic bit model_stall();
      return m.valid && m.mr && m.rd != 5'd31 && bus.id_valid &&
             (m.rd == bus.id_rs1 || (m.rd == bus.id_rs2 && !bus.id_use_imm));
   endfunction

   // Reference: one in-flight instruction record updated by the stage's priority rules.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m = '{default: '0};
      end else if (bus.flush) begin
         m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      end else if (bus.hold) begin
         logic [63:0] f1, f2;
         f1 = fwd(m.rs1, m.v1);
         f2 = fwd(m.rs2, m.v2);
         m.v1 = f1;
         m.v2 = f2;
      end else if (model_stall()) begin
         m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      end else begin
         m.valid = bus.id_valid;     m.op = bus.id_alu_op;
         m.rs1 = bus.id_rs1;         m.rs2 = bus.id_rs2;       m.rd = bus.id_rd;
         m.v1 = bus.id_rs1_data;     m.v2 = bus.id_rs2_data;   m.imm = bus.id_imm;
         m.use_imm = bus.id_use_imm; m.shamt = bus.id_shamt;
         m.rw = bus.id_reg_write;    m.mr = bus.id_mem_read;   m.mw = bus.id_mem_write;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("ex_valid", 64'(bus.ex_valid), 64'(m.valid));
         chk("ex_rd", 64'(bus.ex_rd), m.valid ? 64'(m.rd) : 64'd0);
         chk("ex_reg_write", 64'(bus.ex_reg_write), 64'(m.valid & m.rw));
         chk("ex_mem_read", 64'(bus.ex_mem_read), 64'(m.valid & m.mr));
         chk("ex_mem_write", 64'(bus.ex_mem_write), 64'(m.valid & m.mw));
         chk("load_use_stall", 64'(bus.load_use_stall), 64'(model_stall()));
         if (m.valid) begin
            chk("ex_op", 64'(bus.ex_op), 64'(m.op));
            chk("ex_shamt", 64'(bus.ex_shamt), 64'(m.shamt));
            chk("ex_a", bus.ex_a, fwd(m.rs1, m.v1));
            chk("ex_b", bus.ex_b, m.use_imm ? m.imm : fwd(m.rs2, m.v2));
            chk("ex_store_data", bus.ex_store_data, fwd(m.rs2, m.v2));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input bit v, input logic [3:0] op, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [63:0] d1, input logic [63:0] d2,
                           input logic [63:0] imm, input bit ui,
                           input bit rw, input bit mr, input bit mw);
      bus.id_valid = v;       bus.id_alu_op = op;
      bus.id_rs1 = rs1;       bus.id_rs2 = rs2;       bus.id_rd = rd;
      bus.id_rs1_data = d1;   bus.id_rs2_data = d2;
      bus.id_imm = imm;       bus.id_use_imm = ui;    bus.id_shamt = 6'd0;
      bus.id_reg_write = rw;  bus.id_mem_read = mr;   bus.id_mem_write = mw;
   endtask

   task automatic set_wr(input bit ew, input logic [4:0] er, input logic [63:0] ev,
                         input bit ww, input logic [4:0] wr, input logic [63:0] wv);
      bus.exm_reg_write = ew; bus.exm_rd = er; bus.exm_result = ev;
      bus.wb_reg_write = ww;  bus.wb_rd = wr;  bus.wb_result = wv;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(bus.ex_valid), 64'd0);
      chk({tag, "_op"}, 64'(bus.ex_op), 64'd0);
      chk({tag, "_a"}, bus.ex_a, 64'd0);
      chk({tag, "_b"}, bus.ex_b, 64'd0);
      chk({tag, "_store"}, bus.ex_store_data, 64'd0);
      chk({tag, "_shamt"}, 64'(bus.ex_shamt), 64'd0);
      chk({tag, "_rd"}, 64'(bus.ex_rd), 64'd0);
      chk({tag, "_ctrl"}, 64'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}), 64'd0);
      chk({tag, "_stall"}, 64'(bus.load_use_stall), 64'd0);
   endtask

   logic [3:0] ops [9] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL,
                           ALU_SRL, ALU_SUB, ALU_LUI, ALU_NOR};

   initial begin
      bus.hold = 0; bus.flush = 0;
      drive_id(0, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0);
      set_wr(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      reset = 0;
      $display("txn reset: outputs idle");

      // Back-to-back dependence: ADD X1 = 5 + 7, then SUB X2 = X1 - 2.
      drive_id(1, ALU_ADD, 5'd10, 5'd11, 5'd1, 64'd5, 64'd7, 64'd0, 0, 1, 0, 0);
      tick();
      drive_id(1, ALU_SUB, 5'd1, 5'd12, 5'd2, 64'd0, 64'd0, 64'd2, 1, 1, 0, 0);
      #1;
      chk("dep_add_a", bus.ex_a, 64'd5);
      chk("dep_add_alu", alu(bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_shamt), 64'd12);
      tick();
      set_wr(1, 5'd1, 64'd12, 0, 5'd0, 64'd0);
      #1;
      chk("dep_sub_a", bus.ex_a, 64'd12);
      chk("dep_sub_b", bus.ex_b, 64'd2);
      chk("dep_sub_alu", alu(bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_shamt), 64'd10);
      $display("txn dependence: ex_a=%0d", bus.ex_a);

      // Double writer on the same register.
      drive_id(1, ALU_OR, 5'd3, 5'd4, 5'd5, 64'h99, 64'h0, 64'd0, 0, 1, 0, 0);
      tick();
      set_wr(1, 5'd3, 64'h20, 1, 5'd3, 64'h10);
      #1;
      chk("dbl_exm_prio", bus.ex_a, 64'h20);
      bus.exm_reg_write = 0;
      #1;
      chk("dbl_wb", bus.ex_a, 64'h10);
      set_wr(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
      $display("txn double writer");

      // XZR source must read zero even with a matching writer.
      drive_id(1, ALU_ADD, 5'd31, 5'd31, 5'd6, 64'hAB, 64'hCD, 64'd0, 0, 1, 0, 0);
      tick();
      set_wr(1, 5'd31, 64'hFF, 1, 5'd31, 64'hEE);
      #1;
      chk("xzr_a", bus.ex_a, 64'd0);
      chk("xzr_store", bus.ex_store_data, 64'd0);
      set_wr(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
      $display("txn xzr");

      // Load-use: LDUR X3, then ADD X4 = X3 + X3.
      drive_id(1, ALU_ADD, 5'd5, 5'd0, 5'd3, 64'h100, 64'd0, 64'd8, 1, 1, 1, 0);
      tick();
      drive_id(1, ALU_ADD, 5'd3, 5'd3, 5'd4, 64'd0, 64'd0, 64'd0, 0, 1, 0, 0);
      #1;
      chk("lu_stall", 64'(bus.load_use_stall), 64'd1);
      chk("lu_load_valid", 64'(bus.ex_valid), 64'd1);
      tick();
      #1;
      chk("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
      chk("lu_bubble_stall", 64'(bus.load_use_stall), 64'd0);
      tick();
      set_wr(0, 5'd0, 64'd0, 1, 5'd3, 64'h77);
      #1;
      chk("lu_add_valid", 64'(bus.ex_valid), 64'd1);
      chk("lu_add_a", bus.ex_a, 64'h77);
      chk("lu_add_b", bus.ex_b, 64'h77);
      set_wr(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
      $display("txn load-use");

      // Hold across a WB retire on rs1.
      drive_id(1, ALU_XOR, 5'd6, 5'd8, 5'd7, 64'h11, 64'h22, 64'd0, 0, 1, 0, 0);
      tick();
      drive_id(1, ALU_AND, 5'd9, 5'd10, 5'd11, 64'h1, 64'h2, 64'd0, 0, 1, 0, 0);
      bus.hold = 1;
      set_wr(0, 5'd0, 64'd0, 1, 5'd6, 64'h55);
      tick();
      set_wr(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
      tick();
      tick();
      bus.hold = 0;
      #1;
      chk("hold_a", bus.ex_a, 64'h55);
      chk("hold_rd", 64'(bus.ex_rd), 64'd7);
      $display("txn hold over retire");

      // Flush with hold, then asynchronous reset mid-cycle.
      bus.flush = 1; bus.hold = 1;
      tick();
      bus.flush = 0; bus.hold = 0;
      #1;
      chk("flush_valid", 64'(bus.ex_valid), 64'd0);
      chk("flush_rw", 64'(bus.ex_reg_write), 64'd0);
      drive_id(1, ALU_NOR, 5'd2, 5'd3, 5'd4, 64'h5, 64'h6, 64'd0, 0, 1, 0, 1);
      tick();
      #1;
      chk("pre_rst_valid", 64'(bus.ex_valid), 64'd1);
      reset = 1;
      #1;
      chk_all_zero("async_rst");
      reset = 0;
      $display("txn flush and async reset");

      for (int i = 0; i < 2000; i++) begin
         logic [4:0] r1, r2, rd;
         r1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         r2 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         drive_id(bit'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0) ? 4'($urandom) : ops[$urandom_range(0, 8)],
                  r1, r2, rd, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 3) == 0));
         bus.id_shamt = 6'($urandom);
         bus.hold = ($urandom_range(0, 6) == 0);
         bus.flush = ($urandom_range(0, 15) == 0);
         set_wr(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom},
                bit'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom});
         tick();
      end
      $display("txn random: 2000 cycles");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
